// File: rtl/fifo_ser_pkg.sv
// Shared types and widths for the sample FIFO serializer.
package fifo_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } ser_state_t;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/ser_clk_div.sv
// Bit-clock divider: sclk toggles every CLK_DIV cycles while run is high,
// with one-cycle strobes in the cycle before each sclk edge.
module ser_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_a,
    input  logic run,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          half_done;

    assign half_done = run && (div_cnt == CW'(CLK_DIV - 1));
    assign rise_tick = half_done && !sclk;
    assign fall_tick = half_done && sclk;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_sample_serializer.sv
// Pops FIFO samples and shifts them MSB-first onto a sclk/ws/sdata DAC link.
// Optional macro FIFO_SER_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module fifo_sample_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CLK_DIV    = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  sclk,
    output logic                  ws,
    output logic                  sdata,
    output logic                  underrun
`ifdef FIFO_SER_UNDERRUN_CNT_EN
    ,output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int LW = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;

    ser_state_t            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  next_valid;
    logic [BW-1:0]         bit_cnt;
    logic [LW-1:0]         lat_cnt;
    logic                  rd_pending;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  pop_idle;
    logic                  pop_pref;
    logic                  capture;
    logic                  lsb_fall;
    logic                  slot_end;

    ser_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_a     (rst_a),
        .run       (state == RUN),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // bit_cnt counts bits already sampled by the DAC, so it reads 0 only at the
    // falling edge that closes a slot and DATA_WIDTH-1 where the LSB goes out.
    assign lsb_fall = (state == RUN) && fall_tick && (bit_cnt == BW'(DATA_WIDTH - 1));
    assign slot_end = (state == RUN) && fall_tick && (bit_cnt == '0);
    assign pop_idle = (state == IDLE) && enable && !fifo_empty;
    assign pop_pref = lsb_fall && enable && !fifo_empty && !next_valid && !rd_pending;
    assign capture  = rd_pending && (lat_cnt == LW'(RD_LATENCY));
    assign sdata    = (state == RUN) && shift_reg[DATA_WIDTH-1];

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            ws         <= 1'b0;
            underrun   <= 1'b0;
            shift_reg  <= '0;
            next_word  <= '0;
            next_valid <= 1'b0;
            bit_cnt    <= '0;
            lat_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            fifo_rd_en <= pop_idle || pop_pref;
            underrun   <= 1'b0;

            if (pop_idle || pop_pref) begin
                rd_pending <= 1'b1;
                lat_cnt    <= '0;
            end else if (capture) begin
                rd_pending <= 1'b0;
            end else if (rd_pending) begin
                lat_cnt <= lat_cnt + LW'(1);
            end

            if (rise_tick) begin
                bit_cnt <= (bit_cnt == BW'(DATA_WIDTH - 1)) ? '0 : bit_cnt + BW'(1);
            end

            case (state)
                IDLE: begin
                    if (pop_idle) state <= PRIME;
                end
                PRIME: begin
                    if (capture) begin
                        shift_reg <= fifo_data;
                        ws        <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        next_word  <= fifo_data;
                        next_valid <= 1'b1;
                    end
                    if (slot_end) begin
                        if (!enable) begin
                            state      <= IDLE;
                            ws         <= 1'b0;
                            shift_reg  <= '0;
                            next_valid <= 1'b0;
                            rd_pending <= 1'b0;
                        end else begin
                            ws <= ~ws;
                            // a word landing on the boundary edge itself is used directly
                            if (next_valid) begin
                                shift_reg  <= next_word;
                                next_valid <= 1'b0;
                            end else if (capture) begin
                                shift_reg  <= fifo_data;
                                next_valid <= 1'b0;
                            end else begin
                                shift_reg <= '0;
                                underrun  <= 1'b1;
                            end
                        end
                    end else if (fall_tick) begin
                        shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_SER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sample_serializer.sv
// Directed bench for fifo_sample_serializer with a queue-based FIFO model.
module tb_fifo_sample_serializer;

    localparam int DW = 16;
    localparam int CD = 2;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst_a;
    logic          enable;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          sclk;
    logic          ws;
    logic          sdata;
    logic          underrun;
`ifdef FIFO_SER_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] fifo_q[$];
    int   rise_cnt = 0;
    int   rd_cnt   = 0;
    int   ur_cnt   = 0;
    int   bad_pop  = 0;
    int   rd_rise  = 0;
    logic prev_sclk = 1'b0;

    always #5 clk = ~clk;

    fifo_sample_serializer #(
        .DATA_WIDTH (DW),
        .CLK_DIV    (CD),
        .RD_LATENCY (RL)
    ) dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .sclk         (sclk),
        .ws           (ws),
        .sdata        (sdata),
        .underrun     (underrun)
`ifdef FIFO_SER_UNDERRUN_CNT_EN
        ,.underrun_cnt (underrun_cnt)
`endif
    );

    // FIFO model: data valid one cycle after the pop strobe
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (sclk && !prev_sclk) rise_cnt++;
        prev_sclk = sclk;
        if (fifo_rd_en) begin
            rd_cnt++;
            rd_rise = rise_cnt;
            if (fifo_empty) bad_pop++;
        end
        if (underrun) ur_cnt++;
    end

    task automatic get_bits(input int n, input int drop_at, output logic [31:0] bits,
                            output logic [31:0] wsb, output int max_gap,
                            output int first_gap, output bit to);
        int   got    = 0;
        int   gap    = 0;
        int   budget = 0;
        logic prev   = sclk;
        bits = '0; wsb = '0; max_gap = 0; first_gap = 0; to = 1'b0;
        while (got < n && !to) begin
            @(negedge clk);
            gap++;
            budget++;
            if (sclk && !prev) begin
                bits = {bits[30:0], sdata};
                wsb  = {wsb[30:0], ws};
                if (got == 0) first_gap = gap;
                else if (gap > max_gap) max_gap = gap;
                gap = 0;
                if (got == drop_at) enable = 1'b0;
                got++;
            end
            prev = sclk;
            if (budget > 2000) to = 1'b1;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        int bad = 0;
        rst_a = 1'b1;
        enable = 1'b1;
        fifo_q.push_back(16'hA5C3);
        repeat (12) begin
            @(negedge clk);
            if ({fifo_rd_en, sclk, ws, sdata, underrun} !== 5'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL reset_quiet: nonzero cycles %0d, expected 0", bad); end
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b exp 0", fifo_rd_en); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b exp 0", sclk); end
        n_checks++; if (sdata !== 1'b0) begin n_fail++; $display("FAIL reset_sdata: got %b exp 0", sdata); end
        n_checks++; if (ws !== 1'b0) begin n_fail++; $display("FAIL reset_ws: got %b exp 0", ws); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b exp 0", underrun); end
`ifdef FIFO_SER_UNDERRUN_CNT_EN
        n_checks++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ucnt: got %0d exp 0", underrun_cnt); end
`endif
        enable = 1'b0;
        rst_a = 1'b0;
        fifo_q.delete();
        settle(4);
    endtask

    task automatic test_single_word;
        logic [31:0] bits, wsb;
        int mg, fg, wait_n, rd0, ur0;
        bit to;
        rd0 = rd_cnt; ur0 = ur_cnt;
        fifo_q.push_back(16'hA5C3);
        enable = 1'b1;
        wait_n = 0;
        do begin @(negedge clk); wait_n++; end while (!fifo_rd_en && wait_n < 50);
        n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_wait: no pop within 50 cycles"); end
        get_bits(16, 8, bits, wsb, mg, fg, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: bits not received"); end
        n_checks++; if (fg !== 4) begin n_fail++; $display("FAIL single_first_rise: pop-to-rise %0d cycles exp 4", fg); end
        n_checks++; if (bits[15:0] !== 16'hA5C3) begin n_fail++; $display("FAIL single_bits: got %h exp a5c3", bits[15:0]); end
        n_checks++; if (wsb[15:0] !== 16'h0000) begin n_fail++; $display("FAIL single_ws: got %h exp 0000", wsb[15:0]); end
        n_checks++; if (mg !== 4) begin n_fail++; $display("FAIL single_gap: got %0d exp 4", mg); end
        settle(20);
        n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL single_pops: got %0d exp 1", rd_cnt - rd0); end
        n_checks++; if (ur_cnt - ur0 !== 0) begin n_fail++; $display("FAIL single_underrun: got %0d exp 0", ur_cnt - ur0); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL single_idle_sclk: got %b exp 0", sclk); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] bits, wsb;
        int mg, fg, rd0, r0;
        bit to;
        fifo_q.push_back(16'h8001);
        fifo_q.push_back(16'h7FFE);
        settle(2);
        rd0 = rd_cnt; r0 = rise_cnt;
        enable = 1'b1;
        get_bits(32, 20, bits, wsb, mg, fg, to);
        settle(20);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: bits not received"); end
        n_checks++; if (bits !== 32'h8001_7FFE) begin n_fail++; $display("FAIL b2b_bits: got %h exp 80017ffe", bits); end
        n_checks++; if (wsb !== 32'h0000_FFFF) begin n_fail++; $display("FAIL b2b_ws: got %h exp 0000ffff", wsb); end
        n_checks++; if (mg !== 4) begin n_fail++; $display("FAIL b2b_gap: max rise spacing %0d exp 4", mg); end
        n_checks++; if (rd_cnt - rd0 !== 2) begin n_fail++; $display("FAIL b2b_pops: got %0d exp 2", rd_cnt - rd0); end
        n_checks++; if (rd_rise - r0 !== 15) begin n_fail++; $display("FAIL b2b_prefetch_pos: pop after %0d rises exp 15", rd_rise - r0); end
    endtask

    task automatic test_underrun;
        logic [31:0] bits, wsb;
        int mg, fg, rd0, ur0;
        bit to;
        fifo_q.push_back(16'h1234);
        settle(2);
        rd0 = rd_cnt; ur0 = ur_cnt;
        enable = 1'b1;
        get_bits(32, 20, bits, wsb, mg, fg, to);
        settle(20);
        n_checks++; if (to) begin n_fail++; $display("FAIL ur_timeout: bits not received"); end
        n_checks++; if (bits !== 32'h1234_0000) begin n_fail++; $display("FAIL ur_bits: got %h exp 12340000", bits); end
        n_checks++; if (wsb !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ur_ws: got %h exp 0000ffff", wsb); end
        n_checks++; if (ur_cnt - ur0 !== 1) begin n_fail++; $display("FAIL ur_pulses: got %0d exp 1", ur_cnt - ur0); end
        n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL ur_pops: got %0d exp 1", rd_cnt - rd0); end
        n_checks++; if (mg !== 4) begin n_fail++; $display("FAIL ur_gap: got %0d exp 4", mg); end
`ifdef FIFO_SER_UNDERRUN_CNT_EN
        n_checks++; if (underrun_cnt !== 16'd1) begin n_fail++; $display("FAIL ur_cnt: got %0d exp 1", underrun_cnt); end
`endif
    endtask

    task automatic test_enable_drop;
        logic [31:0] bits, wsb;
        int mg, fg, rd0, r0;
        bit to;
        fifo_q.push_back(16'hFFFF);
        fifo_q.push_back(16'h1111);
        settle(2);
        rd0 = rd_cnt; r0 = rise_cnt;
        enable = 1'b1;
        get_bits(16, 5, bits, wsb, mg, fg, to);
        settle(30);
        n_checks++; if (to) begin n_fail++; $display("FAIL drop_timeout: bits not received"); end
        n_checks++; if (bits[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL drop_bits: got %h exp ffff", bits[15:0]); end
        n_checks++; if (rise_cnt - r0 !== 16) begin n_fail++; $display("FAIL drop_rises: got %0d exp 16", rise_cnt - r0); end
        n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL drop_pops: got %0d exp 1", rd_cnt - rd0); end
        n_checks++; if (fifo_q.size() !== 1) begin n_fail++; $display("FAIL drop_fifo_left: got %0d exp 1", fifo_q.size()); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL drop_idle_sclk: got %b exp 0", sclk); end
        fifo_q.delete();
        settle(3);
    endtask

    task automatic test_reset_mid_slot;
        logic [31:0] bits, wsb;
        int mg, fg, rd0;
        bit to;
        fifo_q.push_back(16'hFFFF);
        fifo_q.push_back(16'hFFFF);
        settle(2);
        enable = 1'b1;
        get_bits(20, -1, bits, wsb, mg, fg, to);
        n_checks++; if (wsb[0] !== 1'b1 || sdata !== 1'b1) begin n_fail++; $display("FAIL mid_pre_state: ws %b sdata %b exp 1 1", wsb[0], sdata); end
        #2 rst_a = 1'b1;
        #1;
        n_checks++; if ({fifo_rd_en, sclk, ws, sdata, underrun} !== 5'b0) begin
            n_fail++; $display("FAIL mid_async_reset: rd/sclk/ws/sdata/ur = %b exp 00000", {fifo_rd_en, sclk, ws, sdata, underrun});
        end
        enable = 1'b0;
        fifo_q.delete();
        settle(3);
        rst_a = 1'b0;
        fifo_q.push_back(16'hC001);
        settle(2);
        rd0 = rd_cnt;
        enable = 1'b1;
        get_bits(16, 4, bits, wsb, mg, fg, to);
        settle(20);
        n_checks++; if (to) begin n_fail++; $display("FAIL mid_restart_timeout: bits not received"); end
        n_checks++; if (bits[15:0] !== 16'hC001) begin n_fail++; $display("FAIL mid_restart_bits: got %h exp c001", bits[15:0]); end
        n_checks++; if (wsb[15:0] !== 16'h0000) begin n_fail++; $display("FAIL mid_restart_ws: got %h exp 0000", wsb[15:0]); end
        n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL mid_restart_pops: got %0d exp 1", rd_cnt - rd0); end
`ifdef FIFO_SER_UNDERRUN_CNT_EN
        n_checks++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_restart_ucnt: got %0d exp 0", underrun_cnt); end
`endif
    endtask

    initial begin
        rst_a  = 1'b0;
        enable = 1'b0;
        #2 rst_a = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_enable_drop();
        test_reset_mid_slot();
        n_checks++; if (bad_pop !== 0) begin n_fail++; $display("FAIL pop_while_empty: got %0d exp 0", bad_pop); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
